health_alarm_fsm: RTL and testbench

//  Downstream consumer of the two 3-bit threshold comparators (value vs LOW limit, value vs HIGH limit).

---
 rtl/health_alarm_fsm_pkg.sv | 26 ++
 rtl/health_alarm_fsm_persist_counter.sv | 50 +++++
 rtl/health_alarm_fsm.sv | 176 +++++++++++++++++
 tb/tb_health_alarm_fsm.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/health_alarm_fsm_pkg.sv
// health_alarm_fsm_pkg
//   Shared definitions for the health alarm qualifier:
//   - FSM state encodings and state width
//   - default persistence count
//   - saturating 8-bit increment used by the optional alarm log counter
package health_alarm_fsm_pkg;

  localparam int ST_W = 2;

  localparam logic [1:0] ST_NORMAL  = 2'd0;
  localparam logic [1:0] ST_SUSPECT = 2'd1;
  localparam logic [1:0] ST_ALARM   = 2'd2;
  localparam logic [1:0] ST_ACKED   = 2'd3;

  localparam int PERSIST_DEFAULT = 3;

  // Increment that sticks at 255 instead of wrapping to 0.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'd255) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/health_alarm_fsm_persist_counter.sv
// persist_counter
//   Counts consecutive out-of-range samples for the health alarm FSM.
//   Synchronous clear, saturating increment (sticks at PERSIST), and a
//   flag that is high when this cycle's increment lands exactly on PERSIST.
// Ports
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-high reset
//   clr  in   synchronous clear; combined with inc the counter restarts at 1
//   inc  in   count one more out-of-range sample
//   cnt  out  current count (registered)
//   hit  out  inc is asserted and the updated count equals PERSIST
module persist_counter #(
  parameter int CNT_W   = 3,
  parameter int PERSIST = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             hit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(PERSIST);

  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] cnt_nxt;

  // Clear takes effect before the increment so clr+inc yields a count of 1.
  always_comb begin
    base    = clr ? {CNT_W{1'b0}} : cnt;
    cnt_nxt = base;
    if (inc && (base != LIMIT)) begin
      cnt_nxt = base + CNT_W'(1);
    end else begin
      cnt_nxt = base;
    end
    hit = inc && (cnt_nxt == LIMIT);
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= {CNT_W{1'b0}};
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/health_alarm_fsm.sv
// health_alarm_fsm
//   Qualifies low/high threshold comparator flags per valid sample and raises
//   a latched alarm after PERSIST consecutive out-of-range samples. The alarm
//   holds until acknowledged; re-arming requires an in-range sample.
//   Optional feature macro: HEALTH_ALARM_LOG_EN (alarm_cnt counts alarms
//   raised, saturating at 255; without it alarm_cnt is constant zero).
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   smp_vld    in   comparator flags valid this cycle
//   lo_lt      in   value below LOW limit
//   lo_eq      in   value equal to LOW limit (in range)
//   hi_gt      in   value above HIGH limit
//   hi_eq      in   value equal to HIGH limit (in range)
//   ack        in   operator acknowledge pulse
//   alarm      out  registered alarm (buzzer)
//   alarm_lo   out  registered: qualifying sample(s) were below LOW
//   alarm_hi   out  registered: qualifying sample(s) were above HIGH
//   state      out  current FSM state
//   alarm_cnt  out  alarms raised since reset
module health_alarm_fsm
  import health_alarm_fsm_pkg::*;
#(
  parameter int PERSIST = PERSIST_DEFAULT,
  parameter int CNT_W   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            smp_vld,
  input  logic            lo_lt,
  input  logic            lo_eq,
  input  logic            hi_gt,
  input  logic            hi_eq,
  input  logic            ack,
  output logic            alarm,
  output logic            alarm_lo,
  output logic            alarm_hi,
  output logic [ST_W-1:0] state,
  output logic [7:0]      alarm_cnt
);

  logic            v_oor;
  logic            v_in;
  logic            cnt_clr;
  logic            cnt_inc;
  logic            cnt_hit;
  logic [CNT_W-1:0] cnt;
  logic [ST_W-1:0] state_nxt;
  logic            lo_nxt;
  logic            hi_nxt;
  logic            eq_unused;

  // Equality flags only mean "in range", which is already implied by the
  // absence of lo_lt/hi_gt.
  assign eq_unused = lo_eq ^ hi_eq;

  // Sample classification; nothing is classified without smp_vld.
  always_comb begin
    v_oor = smp_vld & (lo_lt | hi_gt);
    v_in  = smp_vld & ~(lo_lt | hi_gt);
  end

  // Persistence counter control: restart on any in-range sample, and restart
  // at 1 when a new out-of-range run begins from NORMAL.
  always_comb begin
    cnt_inc = v_oor;
    if (v_in || ((state == ST_NORMAL) && v_oor)) begin
      cnt_clr = 1'b1;
    end else begin
      cnt_clr = 1'b0;
    end
  end

  persist_counter #(
    .CNT_W   (CNT_W),
    .PERSIST (PERSIST)
  ) u_persist (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (cnt),
    .hit (cnt_hit)
  );

  // Next-state and direction-flag logic.
  always_comb begin
    state_nxt = state;
    lo_nxt    = alarm_lo;
    hi_nxt    = alarm_hi;
    case (state)
      ST_NORMAL, ST_SUSPECT: begin
        if (v_oor) begin
          if (cnt_hit) begin
            // Entry into ALARM: flags come from the qualifying sample.
            state_nxt = ST_ALARM;
            lo_nxt    = lo_lt;
            hi_nxt    = hi_gt;
          end else begin
            state_nxt = ST_SUSPECT;
          end
        end else if (v_in) begin
          state_nxt = ST_NORMAL;
        end else begin
          state_nxt = state;
        end
      end
      ST_ALARM: begin
        if (ack && v_in) begin
          state_nxt = ST_NORMAL;
          lo_nxt    = 1'b0;
          hi_nxt    = 1'b0;
        end else begin
          if (ack) begin
            state_nxt = ST_ACKED;
          end else begin
            state_nxt = ST_ALARM;
          end
          if (v_oor) begin
            lo_nxt = alarm_lo | lo_lt;
            hi_nxt = alarm_hi | hi_gt;
          end else begin
            lo_nxt = alarm_lo;
            hi_nxt = alarm_hi;
          end
        end
      end
      ST_ACKED: begin
        // Re-arm only after an in-range sample; ack has no effect here.
        if (v_in) begin
          state_nxt = ST_NORMAL;
          lo_nxt    = 1'b0;
          hi_nxt    = 1'b0;
        end else begin
          state_nxt = ST_ACKED;
        end
      end
      default: begin
        state_nxt = ST_NORMAL;
        lo_nxt    = 1'b0;
        hi_nxt    = 1'b0;
      end
    endcase
  end

  // State and output registers; alarm follows the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_NORMAL;
      alarm    <= 1'b0;
      alarm_lo <= 1'b0;
      alarm_hi <= 1'b0;
    end else begin
      state    <= state_nxt;
      alarm    <= (state_nxt == ST_ALARM);
      alarm_lo <= lo_nxt;
      alarm_hi <= hi_nxt;
    end
  end

`ifdef HEALTH_ALARM_LOG_EN
  // Alarm log: counts entries into ALARM, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_cnt <= 8'd0;
    end else if ((state_nxt == ST_ALARM) && (state != ST_ALARM)) begin
      alarm_cnt <= sat_inc8(alarm_cnt);
    end else begin
      alarm_cnt <= alarm_cnt;
    end
  end
`else
  assign alarm_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_health_alarm_fsm.sv
// tb_health_alarm_fsm
//   Directed self-checking bench for health_alarm_fsm (PERSIST=3).
module tb_health_alarm_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       smp_vld = 1'b0;
  logic       lo_lt = 1'b0;
  logic       lo_eq = 1'b0;
  logic       hi_gt = 1'b0;
  logic       hi_eq = 1'b0;
  logic       ack = 1'b0;
  logic       alarm;
  logic       alarm_lo;
  logic       alarm_hi;
  logic [1:0] state;
  logic [7:0] alarm_cnt;

  int errors = 0;
  int checks = 0;

  health_alarm_fsm #(.PERSIST(3), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .smp_vld   (smp_vld),
    .lo_lt     (lo_lt),
    .lo_eq     (lo_eq),
    .hi_gt     (hi_gt),
    .hi_eq     (hi_eq),
    .ack       (ack),
    .alarm     (alarm),
    .alarm_lo  (alarm_lo),
    .alarm_hi  (alarm_hi),
    .state     (state),
    .alarm_cnt (alarm_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then settle after the rising edge.
  task automatic step(input logic v, input logic lt, input logic leq,
                      input logic gt, input logic heq, input logic a);
    @(negedge clk);
    smp_vld = v; lo_lt = lt; lo_eq = leq; hi_gt = gt; hi_eq = heq; ack = a;
    @(posedge clk);
    #1;
    smp_vld = 1'b0; lo_lt = 1'b0; lo_eq = 1'b0; hi_gt = 1'b0; hi_eq = 1'b0; ack = 1'b0;
  endtask

  // Compare state, alarm, alarm_lo, alarm_hi in one go.
  task automatic chk4(input string tag, input logic [1:0] st, input logic al,
                      input logic lo, input logic hi);
    chk({tag, ".state"}, {6'd0, state}, {6'd0, st});
    chk({tag, ".alarm"}, {7'd0, alarm}, {7'd0, al});
    chk({tag, ".lo"},    {7'd0, alarm_lo}, {7'd0, lo});
    chk({tag, ".hi"},    {7'd0, alarm_hi}, {7'd0, hi});
  endtask

  initial begin
    // Reset state
    #2;
    chk4("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.cnt", alarm_cnt, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Three low samples raise the alarm after the third edge
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk4("lo1", 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk4("lo2", 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk4("lo3", 2'd2, 1'b1, 1'b1, 1'b0);
`ifdef HEALTH_ALARM_LOG_EN
    chk("log.first", alarm_cnt, 8'd1);
`else
    chk("log.off1", alarm_cnt, 8'd0);
`endif

    // Asynchronous reset mid-alarm, no clock edge needed
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk4("async_rst", 2'd0, 1'b0, 1'b0, 1'b0);
    chk("async_rst.cnt", alarm_cnt, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Two out-of-range, then in-range (equal to LOW) returns to NORMAL
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk4("two_oor", 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk4("back_in", 2'd0, 1'b0, 1'b0, 1'b0);

    // Valid gaps: vld 1,0,0,1,1 (flags held high while invalid)
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk4("gap_hold", 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk4("gap_v2", 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk4("gap_v3", 2'd2, 1'b1, 1'b1, 1'b0);

    // Ack -> ACKED; high samples stay ACKED with flags unchanged; hi_eq re-arms
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk4("ack", 2'd3, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk4("acked_oor", 2'd3, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk4("acked_clear", 2'd0, 1'b0, 1'b0, 1'b0);

    // Misordered limits: both flags set together
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk4("both", 2'd2, 1'b1, 1'b1, 1'b1);
    // In-range without ack keeps the alarm latched
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk4("latched", 2'd2, 1'b1, 1'b1, 1'b1);
    // Ack together with in-range sample goes straight to NORMAL
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk4("ack_in", 2'd0, 1'b0, 1'b0, 1'b0);

    // Ack ignored in NORMAL and SUSPECT
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk4("ack_normal", 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk4("ack_suspect", 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk4("hi_alarm", 2'd2, 1'b1, 1'b0, 1'b1);
    // Further low sample in ALARM accumulates alarm_lo
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk4("accum", 2'd2, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk4("ack_twice", 2'd3, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk4("rearm", 2'd0, 1'b0, 1'b0, 1'b0);

`ifdef HEALTH_ALARM_LOG_EN
    // Saturation of the alarm log after many alarm/ack/clear rounds
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 9) chk("log.ten", alarm_cnt, 8'd10);
    end
    chk("log.sat", alarm_cnt, 8'd255);
`else
    chk("log.off_end", alarm_cnt, 8'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
